// File: rtl/ofm_bram_reader.sv
// Output feature map drain: reads num_lines BRAM lines from base_addr, unpacks each line
// LSB-first into ACC_WIDTH words and streams them over a registered valid/ready port.
module ofm_bram_reader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_lines,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [ACC_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned WPL   = DATA_WIDTH / ACC_WIDTH;
  localparam int unsigned IDX_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned CNT_W = LEN_WIDTH + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPL - 1);
  localparam bit SINGLE_WORD = (WPL == 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  num_q, num_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      started_q, started_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_vld_q;
  logic [ACC_WIDTH-1:0]  m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [CNT_W-1:0]      num_ext;
  logic                  accept, push, pop;
  logic [1:0]            remaining;
  logic                  head_ptr;
  logic [IDX_W-1:0]      nidx;
  logic [2:0]            occupancy;
  logic                  load_new;
  logic [DATA_WIDTH-1:0] src_line;

  assign num_ext   = CNT_W'(num_q);
  assign accept    = m_valid_q && m_ready;
  // Read data returns two edges after the address is launched; rd_vld_q marks that edge.
  assign push      = rd_vld_q;
  assign pop       = accept && (idx_q == LAST_IDX);
  assign remaining = cnt_q - {1'b0, pop};
  assign head_ptr  = rd_ptr_q ^ pop;
  assign nidx      = idx_q + 1'b1;
  // Credit: buffered lines plus both stages of an outstanding read must stay below two.
  assign occupancy = {1'b0, cnt_q} + {2'b00, en_q} + {2'b00, rd_vld_q};

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    next_addr_d = next_addr_q;
    issued_d    = issued_q;
    started_d   = started_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    idx_d       = idx_q;
    load_new    = 1'b0;
    src_line    = bram_rdata;

    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};

    // Output register: advance within the head line, else move to the next available line.
    if (!m_valid_q || m_ready) begin
      if (m_valid_q && (idx_q != LAST_IDX)) begin
        idx_d     = nidx;
        m_data_d  = buf_q[rd_ptr_q][nidx*ACC_WIDTH +: ACC_WIDTH];
        m_valid_d = 1'b1;
        m_last_d  = (nidx == LAST_IDX) && (started_q == num_ext);
      end else begin
        if (remaining != 2'd0) begin
          src_line = buf_q[head_ptr];
          load_new = 1'b1;
        end else if (push) begin
          src_line = bram_rdata;
          load_new = 1'b1;
        end
        if (load_new) begin
          idx_d     = '0;
          m_data_d  = src_line[ACC_WIDTH-1:0];
          m_valid_d = 1'b1;
          started_d = started_q + 1'b1;
          m_last_d  = SINGLE_WORD && ((started_q + 1'b1) == num_ext);
        end else begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_lines;
          issued_d  = '0;
          started_d = '0;
          if (num_lines != '0) begin
            state_d     = S_RUN;
            en_d        = 1'b1;
            addr_d      = base_addr;
            next_addr_d = base_addr + 1'b1;
            issued_d    = CNT_W'(1);
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_RUN: begin
        if ((issued_q < num_ext) && (occupancy < 3'd2)) begin
          en_d        = 1'b1;
          addr_d      = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          issued_d    = issued_q + 1'b1;
        end
        if (pop && m_last_q) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      next_addr_q <= '0;
      issued_q    <= '0;
      started_q   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      idx_q       <= '0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      next_addr_q <= next_addr_d;
      issued_q    <= issued_d;
      started_q   <= started_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      rd_vld_q    <= en_q;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      idx_q       <= idx_d;
      if (push) begin
        buf_q[wr_ptr_q] <= bram_rdata;
      end
    end
  end

  assign bram_en   = en_q;
  assign bram_addr = addr_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_FINISH);
  assign done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_ofm_bram_reader.sv
// Directed bench for ofm_bram_reader: BRAM model, word/address scoreboards, stall and
// occupancy monitors, reset/abort and wrap-around scenarios.
module tb_ofm_bram_reader;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   base_addr;
  logic [15:0]   num_lines;
  logic          bram_en;
  logic [31:0]   bram_addr;
  logic [127:0]  bram_rdata;
  logic [15:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] aq [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = -10;
  int en_events = 0;
  int valid_events = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;
  int wcnt = 0;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  bit rand_ready = 1'b0;

  ofm_bram_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_lines  (num_lines),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    if (a == 32'h20) begin
      l = 128'h0123_4567_89AB_CDEF_0011_2233_4455_660F;
    end else begin
      for (int j = 0; j < 8; j++) l[j*16 +: 16] = {a[11:0], 4'(j)};
    end
    return l;
  endfunction

  always @(posedge clk) if (bram_en) bram_rdata <= line_of(bram_addr);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboards, stall stability, buffer occupancy.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      rd_cnt = 0;
      pop_cnt = 0;
      wcnt = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 128'(m_valid), 128'(1));
        check("stall_data", 128'(m_data), 128'(prev_data));
        check("stall_last", 128'(m_last), 128'(prev_last));
      end
      if (bram_en) begin
        en_events++;
        rd_cnt++;
        check("addr_expected", 128'(aq.size() != 0), 128'(1));
        if (aq.size() != 0) check("bram_addr", 128'(bram_addr), 128'(aq.pop_front()));
        check("lines_held_le2", 128'((rd_cnt - pop_cnt) <= 2), 128'(1));
      end
      if (m_valid) valid_events++;
      if (m_valid && m_ready) begin
        check("word_expected", 128'(sb.size() != 0), 128'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", 128'(m_data), 128'(e.d));
          check("word_last", 128'(m_last), 128'(e.l));
        end
        wcnt++;
        if (wcnt % 8 == 0) pop_cnt++;
        if (m_last) hs_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Drives a start pulse; returns #1 after the sampling edge.
  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, input bit expect_it);
    logic [127:0] l;
    if (expect_it) begin
      for (int k = 0; k < int'(n); k++) begin
        logic [31:0] a;
        a = b + 32'(k);
        aq.push_back(a);
        l = line_of(a);
        for (int j = 0; j < 8; j++) begin
          exp_t e;
          e.d = l[j*16 +: 16];
          e.l = (k == int'(n) - 1) && (j == 7);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    num_lines = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1));
    if (seen) begin
      check({tag, "_done_after_last"}, 128'(cyc), 128'(hs_cyc + 1));
      @(negedge clk);
      check({tag, "_done_pulse"}, 128'(done), 128'(0));
      check({tag, "_busy_low"}, 128'(busy), 128'(0));
    end
    check({tag, "_words_left"}, 128'(sb.size()), 128'(0));
    check({tag, "_reads_left"}, 128'(aq.size()), 128'(0));
  endtask

  initial begin
    int e0, v0, dn;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_lines = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bram_en", 128'(bram_en), 128'(0));
    check("rst_bram_addr", 128'(bram_addr), 128'(0));
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_m_data", 128'(m_data), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    rst = 1'b0;

    // 1: basic two-line transfer and latency
    pulse_start(32'h10, 16'd2, 1'b1);
    @(negedge clk);
    check("t1_en_after_e0", 128'(bram_en), 128'(1));
    check("t1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    check("t1_valid_e1", 128'(m_valid), 128'(0));
    @(negedge clk);
    check("t1_valid_e2", 128'(m_valid), 128'(1));
    wait_done("t1", 200);

    // 2: LSB-first unpacking of a known line
    pulse_start(32'h20, 16'd1, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_word0", 128'(m_data), 128'(16'h660F));
    repeat (7) @(negedge clk);
    check("t2_word7", 128'(m_data), 128'(16'h0123));
    check("t2_word7_last", 128'(m_last), 128'(1));
    wait_done("t2", 50);

    // 3: random backpressure
    rand_ready = 1'b1;
    pulse_start(32'h100, 16'd4, 1'b1);
    wait_done("t3", 2000);
    rand_ready = 1'b0;

    // 4: zero-length transfer
    e0 = en_events;
    v0 = valid_events;
    pulse_start(32'h200, 16'd0, 1'b1);
    @(negedge clk);
    check("t4_done", 128'(done), 128'(1));
    check("t4_busy", 128'(busy), 128'(1));
    @(negedge clk);
    check("t4_done_pulse", 128'(done), 128'(0));
    repeat (3) @(negedge clk);
    check("t4_no_reads", 128'(en_events - e0), 128'(0));
    check("t4_no_words", 128'(valid_events - v0), 128'(0));

    // 5: address wrap
    pulse_start(32'hFFFF_FFFF, 16'd2, 1'b1);
    wait_done("t5", 200);

    // 6a: start while busy is ignored
    rand_ready = 1'b1;
    pulse_start(32'h300, 16'd3, 1'b1);
    repeat (4) @(posedge clk);
    pulse_start(32'h500, 16'd5, 1'b0);
    wait_done("t6a", 2000);
    rand_ready = 1'b0;

    // 6b: asynchronous reset mid-transfer
    pulse_start(32'h400, 16'd3, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6b_rst_bram_en", 128'(bram_en), 128'(0));
    check("t6b_rst_bram_addr", 128'(bram_addr), 128'(0));
    check("t6b_rst_m_valid", 128'(m_valid), 128'(0));
    check("t6b_rst_m_data", 128'(m_data), 128'(0));
    check("t6b_rst_m_last", 128'(m_last), 128'(0));
    check("t6b_rst_busy", 128'(busy), 128'(0));
    check("t6b_rst_done", 128'(done), 128'(0));
    sb.delete();
    aq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("t6b_no_done_after_abort", 128'(dn), 128'(0));
    pulse_start(32'h600, 16'd3, 1'b1);
    wait_done("t6b_fresh", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
